// File: rtl/softmax_row_arbiter.sv
// softmax_row_arbiter
// Shares one fixed-latency softmax normalisation backend between NUM_REQ
// requesters. Grants one row per cycle round-robin, tracks every issued row in
// a tag pipe matched to the backend latency, and routes each backend result
// back to the requester that issued it. Enable/flush sequencing is handled by
// a small FSM; a sticky flag records any backend/tag misalignment.
module softmax_row_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int PIPE_LAT = 3,
    parameter int SEL_W    = 2,
    parameter int CNT_W    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               flush,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_grant,
    output logic [SEL_W-1:0]   sm_sel,
    output logic               sm_valid_in,
    input  logic               sm_valid_out,
    output logic [NUM_REQ-1:0] resp_valid,
    output logic [SEL_W-1:0]   resp_id,
    output logic               busy,
    output logic [CNT_W-1:0]   inflight_cnt,
    output logic               flush_done,
    output logic               tag_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_r;
    logic [SEL_W-1:0]   rr_ptr_r;
    logic               tag_v_r  [PIPE_LAT];
    logic [SEL_W-1:0]   tag_id_r [PIPE_LAT];
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_next_s;
    logic               busy_r;
    logic               flush_done_r;
    logic               tag_err_r;

    logic               grant_en_s;
    logic               found_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [SEL_W-1:0]   sel_s;
    logic               tail_v_s;
    logic [SEL_W-1:0]   tail_id_s;
    logic [NUM_REQ-1:0] resp_valid_s;
    logic [SEL_W-1:0]   resp_id_s;

    // Granting is blocked in the very cycle enable drops or flush arrives.
    assign grant_en_s = (state_r == ST_RUN) && enable && !flush;
    assign tail_v_s   = tag_v_r[PIPE_LAT-1];
    assign tail_id_s  = tag_id_r[PIPE_LAT-1];

    // Round-robin winner search starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int idx;
        grant_s = '0;
        sel_s   = '0;
        found_s = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_r) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end else begin
                idx = idx;
            end
            if (grant_en_s && !found_s && req_valid[idx]) begin
                found_s      = 1'b1;
                grant_s[idx] = 1'b1;
                sel_s        = idx[SEL_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Route the backend result to the owner recorded at the tail of the tag pipe.
    always_comb begin
        resp_valid_s = '0;
        resp_id_s    = '0;
        if (tail_v_s) begin
            resp_id_s = tail_id_s;
            if (sm_valid_out) begin
                resp_valid_s[tail_id_s] = 1'b1;
            end else begin
                resp_valid_s = '0;
            end
        end else begin
            resp_id_s = '0;
        end
    end

    // Next in-flight count: +1 per issue, -1 per retirement at the tail.
    always_comb begin
        case ({found_s, tail_v_s})
            2'b10:   cnt_next_s = cnt_r + CNT_W'(1);
            2'b01:   cnt_next_s = cnt_r - CNT_W'(1);
            default: cnt_next_s = cnt_r;
        endcase
    end

    // Sequencing FSM with registered busy and one-cycle flush_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            flush_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (flush) begin
                        state_r      <= ST_DONE;
                        busy_r       <= 1'b1;
                        flush_done_r <= 1'b1;
                    end else if (enable) begin
                        state_r      <= ST_RUN;
                        busy_r       <= 1'b1;
                        flush_done_r <= 1'b0;
                    end else begin
                        state_r      <= ST_IDLE;
                        busy_r       <= (cnt_next_s != '0);
                        flush_done_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state_r      <= ST_DRAIN;
                        busy_r       <= 1'b1;
                        flush_done_r <= 1'b0;
                    end else if (!enable) begin
                        state_r      <= ST_IDLE;
                        busy_r       <= (cnt_next_s != '0);
                        flush_done_r <= 1'b0;
                    end else begin
                        state_r      <= ST_RUN;
                        busy_r       <= 1'b1;
                        flush_done_r <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_next_s == '0) begin
                        state_r      <= ST_DONE;
                        busy_r       <= 1'b1;
                        flush_done_r <= 1'b1;
                    end else begin
                        state_r      <= ST_DRAIN;
                        busy_r       <= 1'b1;
                        flush_done_r <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_r      <= ST_IDLE;
                    busy_r       <= (cnt_next_s != '0);
                    flush_done_r <= 1'b0;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    busy_r       <= 1'b0;
                    flush_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Advance the round-robin pointer past the winner; hold when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= '0;
        end else if (found_s) begin
            if (sel_s == SEL_W'(NUM_REQ - 1)) begin
                rr_ptr_r <= '0;
            end else begin
                rr_ptr_r <= sel_s + SEL_W'(1);
            end
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Tag pipe shifts every cycle so its tail lines up with backend valid_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                tag_v_r[i]  <= 1'b0;
                tag_id_r[i] <= '0;
            end
        end else begin
            for (int i = PIPE_LAT - 1; i > 0; i--) begin
                tag_v_r[i]  <= tag_v_r[i-1];
                tag_id_r[i] <= tag_id_r[i-1];
            end
            tag_v_r[0]  <= found_s;
            tag_id_r[0] <= sel_s;
        end
    end

    // In-flight counter and sticky misalignment flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= '0;
            tag_err_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_next_s;
            tag_err_r <= tag_err_r | (sm_valid_out != tail_v_s);
        end
    end

    assign req_grant    = grant_s;
    assign sm_sel       = sel_s;
    assign sm_valid_in  = found_s;
    assign resp_valid   = resp_valid_s;
    assign resp_id      = resp_id_s;
    assign busy         = busy_r;
    assign inflight_cnt = cnt_r;
    assign flush_done   = flush_done_r;
    assign tag_err      = tag_err_r;

endmodule

// File: tb/tb_softmax_row_arbiter.sv
// Self-checking bench for softmax_row_arbiter (NUM_REQ=4, PIPE_LAT=3).
// A transaction-level model (mode, round-robin pointer, queue of rows with
// their due cycle) predicts every output each cycle; a simple echo backend
// returns valid PIPE_LAT cycles after each issue, optionally with an injected
// orphan pulse.
module tb_softmax_row_arbiter;

    localparam int N   = 4;
    localparam int LAT = 3;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_DONE  = 3;

    logic         clk;
    logic         rst_n;
    logic         enable;
    logic         flush;
    logic [N-1:0] req_valid;
    logic [N-1:0] req_grant;
    logic [1:0]   sm_sel;
    logic         sm_valid_in;
    logic         sm_valid_out;
    logic [N-1:0] resp_valid;
    logic [1:0]   resp_id;
    logic         busy;
    logic [1:0]   inflight_cnt;
    logic         flush_done;
    logic         tag_err;

    softmax_row_arbiter #(.NUM_REQ(N), .PIPE_LAT(LAT), .SEL_W(2), .CNT_W(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_grant    (req_grant),
        .sm_sel       (sm_sel),
        .sm_valid_in  (sm_valid_in),
        .sm_valid_out (sm_valid_out),
        .resp_valid   (resp_valid),
        .resp_id      (resp_id),
        .busy         (busy),
        .inflight_cnt (inflight_cnt),
        .flush_done   (flush_done),
        .tag_err      (tag_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int       ms;
    int       rr;
    int       cyc;
    int       q_due[$];
    int       q_id[$];
    logic     err_m;
    logic [LAT-1:0] bk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        ms    = M_IDLE;
        rr    = 0;
        q_due.delete();
        q_id.delete();
        err_m = 1'b0;
        bk    = '0;
    endtask

    // One clock: apply inputs, predict and check, then advance the model.
    task automatic cycle(input logic [N-1:0] rv, input logic en, input logic fl, input logic inj);
        int   w;
        int   tid;
        int   ix;
        logic tv;
        logic svo;
        logic [N-1:0] eg;
        logic [N-1:0] er;
        req_valid = rv;
        enable    = en;
        flush     = fl;
        tv  = (q_due.size() > 0) && (q_due[0] == cyc);
        tid = tv ? q_id[0] : 0;
        svo = bk[LAT-1] | inj;
        sm_valid_out = svo;
        w = -1;
        if (ms == M_RUN && en && !fl) begin
            for (int k = 0; k < N; k++) begin
                ix = (rr + k) % N;
                if (w < 0 && rv[ix]) w = ix;
            end
        end
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        er = '0;
        if (tv && svo) er[tid] = 1'b1;
        #3;
        chk("req_grant",    req_grant,    eg);
        chk("sm_sel",       sm_sel,       (w >= 0) ? w : 0);
        chk("sm_valid_in",  sm_valid_in,  (w >= 0) ? 1 : 0);
        chk("resp_valid",   resp_valid,   er);
        chk("resp_id",      resp_id,      tv ? tid : 0);
        chk("inflight_cnt", inflight_cnt, q_due.size());
        chk("busy",         busy,         (ms != M_IDLE || q_due.size() > 0) ? 1 : 0);
        chk("flush_done",   flush_done,   (ms == M_DONE) ? 1 : 0);
        chk("tag_err",      tag_err,      err_m);
        @(posedge clk);
        if (svo != tv) err_m = 1'b1;
        if (tv) begin
            void'(q_due.pop_front());
            void'(q_id.pop_front());
        end
        if (w >= 0) begin
            q_due.push_back(cyc + LAT);
            q_id.push_back(w);
            rr = (w + 1) % N;
        end
        bk = {bk[LAT-2:0], (w >= 0)};
        case (ms)
            M_IDLE:  ms = fl ? M_DONE : (en ? M_RUN : M_IDLE);
            M_RUN:   ms = fl ? M_DRAIN : (en ? M_RUN : M_IDLE);
            M_DRAIN: ms = (q_due.size() == 0) ? M_DONE : M_DRAIN;
            default: ms = M_IDLE;
        endcase
        cyc++;
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        enable = 1'b0;
        flush = 1'b0;
        req_valid = '0;
        sm_valid_out = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        cyc = 0;
        model_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        flush = 1'b0;
        req_valid = '0;
        sm_valid_out = 1'b0;
        #3;
        // Reset state
        chk("rst_grant", req_grant, 0);
        chk("rst_vin",   sm_valid_in, 0);
        chk("rst_resp",  resp_valid, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_cnt",   inflight_cnt, 0);
        chk("rst_fdone", flush_done, 0);
        chk("rst_err",   tag_err, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single request from requester 2
        cycle(4'b0000, 1'b1, 1'b0, 1'b0);
        cycle(4'b0100, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(4'b0000, 1'b1, 1'b0, 1'b0);

        // Skip and wrap: pointer now 3, requesters 0 and 1 pending
        cycle(4'b0011, 1'b1, 1'b0, 1'b0);
        cycle(4'b0011, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(4'b0000, 1'b1, 1'b0, 1'b0);

        // Round-robin fairness from reset
        reset_dut();
        cycle(4'b1111, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(4'b1111, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(4'b0000, 1'b1, 1'b0, 1'b0);

        // Flush with three rows in flight
        cycle(4'b0001, 1'b1, 1'b0, 1'b0);
        cycle(4'b0010, 1'b1, 1'b0, 1'b0);
        cycle(4'b1000, 1'b1, 1'b0, 1'b0);
        cycle(4'b1111, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) cycle(4'b1111, 1'b0, 1'b0, 1'b0);

        // Randomised traffic with occasional enable drops and flushes
        for (int i = 0; i < 300; i++) begin
            cycle(4'($urandom_range(0, 15)),
                  ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 24) == 0),
                  1'b0);
        end
        for (int i = 0; i < 6; i++) cycle(4'b0000, 1'b0, 1'b0, 1'b0);

        // Orphan backend valid with an empty tag pipe, then normal traffic
        cycle(4'b0000, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            cycle(4'($urandom_range(0, 15)), 1'b1, 1'b0, 1'b0);
        end

        // Asynchronous reset mid-stream with two rows in flight
        cycle(4'b1111, 1'b1, 1'b0, 1'b0);
        cycle(4'b1111, 1'b1, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_grant", req_grant, 0);
        chk("arst_sel",   sm_sel, 0);
        chk("arst_vin",   sm_valid_in, 0);
        chk("arst_resp",  resp_valid, 0);
        chk("arst_id",    resp_id, 0);
        chk("arst_busy",  busy, 0);
        chk("arst_cnt",   inflight_cnt, 0);
        chk("arst_fdone", flush_done, 0);
        chk("arst_err",   tag_err, 0);
        model_reset();
        sm_valid_out = 1'b0;
        enable = 1'b0;
        req_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cycle(4'b1111, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/softmax_row_arbiter.md
Name: softmax_row_arbiter

Overview:
- Shares the single softmax backend normalisation pipeline between NUM_REQ requesters, one row per issue. Typical requesters are attention heads or score-row buffers.
- Grants one requester per cycle, round-robin. Drives the backend valid_in and the input-mux select.
- Tracks each in-flight row with a fixed-latency tag pipe and routes the backend valid_out back to the owning requester.
- Provides enable/flush sequencing and a sticky alignment-error flag.

Parameters:
- NUM_REQ, 4, number of requesters; 2..16.
- PIPE_LAT, 3, clocks from backend valid_in sampled to backend valid_out asserted.
- SEL_W, 2, width of requester index; must equal clog2(NUM_REQ).
- CNT_W, 2, width of in-flight count; must equal clog2(PIPE_LAT+1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  level; granting is allowed only while high and FSM is in RUN.
- flush  in  1  pulse; stop granting, drain in-flight rows, then signal flush_done.
- req_valid  in  NUM_REQ  requester i has a row ready.
- req_grant  out  NUM_REQ  one-hot, combinational; requester i's row is issued this cycle and it pops.
- sm_sel  out  SEL_W  index of the granted requester (drives the exp_values/exp_sum input mux); 0 when no grant.
- sm_valid_in  out  1  equals |req_grant.
- sm_valid_out  in  1  backend result-valid.
- resp_valid  out  NUM_REQ  one-hot, combinational; the backend result belongs to requester i this cycle.
- resp_id  out  SEL_W  index of the result owner; 0 when none.
- busy  out  1  registered; state is not IDLE or any tag is in flight.
- inflight_cnt  out  CNT_W  registered count of valid tag-pipe entries.
- flush_done  out  1  registered, one-cycle pulse.
- tag_err  out  1  sticky; cleared only by reset.

Behaviour:
- Reset: FSM=IDLE; rr_ptr=0; tag pipe cleared; inflight_cnt=0, busy=0, flush_done=0, tag_err=0.
  - Combinational outputs are then 0.
  - A reset mid-operation drops all in-flight rows; the backend shares the same reset.
- FSM states IDLE, RUN, DRAIN, DONE:
  - IDLE→RUN when enable=1 and flush=0.
  - IDLE→DONE when flush=1.
  - RUN→DRAIN when flush=1; flush has priority over enable.
  - RUN→IDLE when enable=0.
  - DRAIN→DONE when the tag pipe is empty after this cycle's shift, i.e. no valid entry left.
  - DONE→IDLE unconditionally; flush_done=1 for exactly that one cycle.
- Arbitration, only in RUN with enable=1 and flush=0:
  - The winner is the first i with req_valid[i] set, searching rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - On a grant, rr_ptr <= winner+1 mod NUM_REQ. With no grant, rr_ptr holds.
  - Grants are issued back-to-back every cycle; the pipeline has no backpressure.
  - No grant is issued in the RUN-exit cycle: enable=0 or flush=1 blocks the grant that same cycle.
- Tag pipe: PIPE_LAT stages of {v, id}, shifting every cycle in every state.
  - Stage 0 loads {sm_valid_in, sm_sel}.
  - The tail entry aligns with the backend valid_out: a grant at cycle t yields resp_valid at cycle t+PIPE_LAT.
- Result routing:
  - resp_valid = sm_valid_out & tail.v, decoded one-hot from tail.id.
  - resp_id = tail.id when tail.v=1, else 0.
- tag_err: set on any cycle where sm_valid_out != tail.v.
  - Routing still follows tail.v & sm_valid_out.
  - An orphan valid_out is dropped.
- inflight_cnt: +1 on issue, −1 when tail.v retires; both in the same cycle leaves it unchanged. Never exceeds PIPE_LAT.
- enable=0 in RUN: the FSM goes to IDLE at once, and rows already in flight still complete and route normally.

Test Plan:
- Single request: NUM_REQ=4, PIPE_LAT=3, enable=1, req_valid=0100 for one cycle at t.
  → req_grant=0100, sm_sel=2, sm_valid_in=1 at t.
  → with a model backend echoing valid at t+3: resp_valid=0100, resp_id=2 at t+3; inflight_cnt 1,1,1 at t+1..t+3, then 0 at t+4.
- Round-robin fairness: req_valid=1111 held for 8 cycles from reset.
  → grants in order 0,1,2,3,0,1,2,3; sm_valid_in=1 every cycle; inflight_cnt saturates at 3; resp_id sequence identical, delayed 3 cycles.
- Skip and wrap: rr_ptr=3, req_valid=0011.
  → grant requester 0, rr_ptr=1; next cycle same request → grant requester 1.
- Flush with rows in flight: 3 consecutive grants, then flush pulse.
  → no grants from the flush cycle; DRAIN until the last resp_valid; flush_done=1 for exactly one cycle after the pipe empties; then IDLE, busy=0.
- Alignment error: inject sm_valid_out=1 with an empty tag pipe.
  → resp_valid=0; tag_err=1 and stays 1 through later normal traffic until rst_n is asserted.
- Asynchronous reset mid-stream: assert rst_n=0 between clock edges while 2 rows are in flight.
  → all outputs 0 immediately; after release, no stale resp_valid appears even if sm_valid_out is 0.
